// File: rtl/mult_pipe_sxs.sv
// Pipelined shift-add multiplier with selectable operand signedness and valid tracking.
// Define MULT_PIPE_ROUND_EN for round-half-up with saturation on the DROP LSBs; otherwise the result is floor-truncated.
module mult_pipe_sxs #(
  parameter int A_W      = 26,
  parameter int B_W      = 14,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 1,
  parameter int DROP     = 0,
  localparam int P_W     = A_W + B_W - DROP
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  output logic           out_valid,
  output logic [P_W-1:0] product
);

  localparam int N  = A_W + B_W;
  localparam int FW = N + 1;
  localparam int EW = N + 2;

  function automatic logic [A_W-1:0] abs_a(input logic [A_W-1:0] x);
    if (A_SIGNED != 0 && x[A_W-1]) return ~x + 1'b1;
    return x;
  endfunction

  function automatic logic [B_W-1:0] abs_b(input logic [B_W-1:0] x);
    if (B_SIGNED != 0 && x[B_W-1]) return ~x + 1'b1;
    return x;
  endfunction

`ifdef MULT_PIPE_ROUND_EN
  localparam bit UNS = (A_SIGNED == 0) && (B_SIGNED == 0);
  localparam logic signed [EW-1:0] HALF =
    (DROP == 0) ? EW'(0) : EW'(1) << ((DROP == 0) ? 0 : DROP - 1);

  // Unsigned x unsigned results are non-negative, so they saturate to all ones.
  function automatic logic [P_W-1:0] shape(input logic signed [FW-1:0] f);
    logic signed [EW-1:0] r;
    if (DROP == 0) return P_W'(f);
    r = $signed({f[FW-1], f}) + HALF;
    r = r >>> DROP;
    if (UNS) begin
      if (r[EW-1:P_W] != '0) return '1;
    end else if (!r[EW-1] && r[EW-2:P_W-1] != '0) begin
      return {1'b0, {(P_W-1){1'b1}}};
    end
    return P_W'(r);
  endfunction
`else
  function automatic logic [P_W-1:0] shape(input logic signed [FW-1:0] f);
    return P_W'(f >>> DROP);
  endfunction
`endif

  logic [N-1:0]         mc_p  [0:B_W-1];
  logic [B_W-1:0]       bb_p  [0:B_W-1];
  logic [N-1:0]         acc_p [0:B_W];
  logic [B_W:0]         s_p;
  logic [B_W:0]         vld_p;
  logic signed [FW-1:0] full_p;
  logic                 vld_f;

  always_ff @(posedge clk) begin
    // stage 0: magnitudes and product sign
    mc_p[0]  <= {{B_W{1'b0}}, abs_a(in_a)};
    bb_p[0]  <= abs_b(in_b);
    acc_p[0] <= '0;
    s_p[0]   <= ((A_SIGNED != 0) & in_a[A_W-1]) ^ ((B_SIGNED != 0) & in_b[B_W-1]);
    // stages 1..B_W: one partial product per stage
    for (int k = 1; k <= B_W; k++) begin
      acc_p[k] <= acc_p[k-1] + (bb_p[k-1][0] ? mc_p[k-1] : '0);
      s_p[k]   <= s_p[k-1];
    end
    for (int k = 1; k < B_W; k++) begin
      mc_p[k] <= mc_p[k-1] << 1;
      bb_p[k] <= bb_p[k-1] >> 1;
    end
    // sign-apply stage; the extra bit keeps unsigned products non-negative
    full_p <= s_p[B_W] ? -$signed({1'b0, acc_p[B_W]}) : $signed({1'b0, acc_p[B_W]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p     <= '0;
      vld_f     <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      vld_p     <= {vld_p[B_W-1:0], in_valid};
      vld_f     <= vld_p[B_W];
      // output stage: product only moves on a valid slot
      out_valid <= vld_f;
      if (vld_f) product <= shape(full_p);
    end
  end

endmodule

// File: tb/tb_mult_pipe_sxs.sv
// Directed-vector bench for mult_pipe_sxs across four configurations (default, 8x8 signed, DROP=8, 4x4 unsigned).
module tb_mult_pipe_sxs;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        iv0, iv1, iv2, iv3;
  logic [25:0] a0, a2;
  logic [13:0] b0, b2;
  logic [7:0]  a1, b1;
  logic [3:0]  a3, b3;
  logic        ov0, ov1, ov2, ov3;
  logic [39:0] p0;
  logic [15:0] p1;
  logic [31:0] p2;
  logic [7:0]  p3;

  mult_pipe_sxs u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_a(a0), .in_b(b0),
                    .out_valid(ov0), .product(p0));
  mult_pipe_sxs #(.A_W(8), .B_W(8), .A_SIGNED(1), .B_SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_a(a1), .in_b(b1),
    .out_valid(ov1), .product(p1));
  mult_pipe_sxs #(.DROP(8)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_a(a2), .in_b(b2),
                                .out_valid(ov2), .product(p2));
  mult_pipe_sxs #(.A_W(4), .B_W(4), .A_SIGNED(0), .B_SIGNED(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_a(a3), .in_b(b3),
    .out_valid(ov3), .product(p3));

  typedef struct {
    int                 sel;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [63:0] exp;
    int                 lat;
  } vec_t;

  typedef struct {
    logic signed [63:0] v;
    int                 due;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  vec_t tbl[$];
  exp_t q[$];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic drive(input int sel, input logic signed [31:0] a, input logic signed [31:0] b,
                       input logic v);
    case (sel)
      0: begin iv0 = v; a0 = a[25:0]; b0 = b[13:0]; end
      1: begin iv1 = v; a1 = a[7:0];  b1 = b[7:0];  end
      2: begin iv2 = v; a2 = a[25:0]; b2 = b[13:0]; end
      default: begin iv3 = v; a3 = a[3:0]; b3 = b[3:0]; end
    endcase
  endtask

  task automatic get(input int sel, output logic ov, output logic signed [63:0] p);
    case (sel)
      0: begin ov = ov0; p = {{24{p0[39]}}, p0}; end
      1: begin ov = ov1; p = {{48{p1[15]}}, p1}; end
      2: begin ov = ov2; p = {{32{p2[31]}}, p2}; end
      default: begin ov = ov3; p = {56'd0, p3}; end
    endcase
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic               ov;
    logic signed [63:0] p;
    int                 lat;
    drive(v.sel, v.a, v.b, 1'b1);
    step();
    drive(v.sel, 0, 0, 1'b0);
    lat = 0;
    get(v.sel, ov, p);
    while (!ov && lat < 40) begin
      step();
      lat++;
      get(v.sel, ov, p);
    end
    chk($sformatf("vec%0d_latency", idx), lat, v.lat);
    chk($sformatf("vec%0d_product", idx), p, v.exp);
    step();
    get(v.sel, ov, p);
    chk($sformatf("vec%0d_pulse", idx), ov, 0);
    chk($sformatf("vec%0d_hold", idx), p, v.exp);
  endtask

  initial begin
    logic               ov;
    logic signed [63:0] p;
    logic [25:0]        ra;
    logic [13:0]        rb;
    longint             la, lb;
    int                 sent, pos, guard, pulses;
    bit                 exp_ov;
    exp_t               e;
    bit                 pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) drive(s, 0, 0, 1'b0);

    tbl.push_back('{0, 1000, -3, -64'sd3000, 16});
    tbl.push_back('{0, 32'sd67108863, -8192, -64'sd549755805696, 16});
    tbl.push_back('{0, 0, -1, 64'sd0, 16});
    tbl.push_back('{0, 12345, 100, 64'sd1234500, 16});
    tbl.push_back('{0, 32'sd67108863, 8191, 64'sd549688696833, 16});
    tbl.push_back('{0, 1, -8192, -64'sd8192, 16});
    tbl.push_back('{0, 3, 5, 64'sd15, 16});
    tbl.push_back('{1, -128, -128, 64'sd16384, 10});
    tbl.push_back('{1, -128, 127, -64'sd16256, 10});
    tbl.push_back('{1, 127, 127, 64'sd16129, 10});
    tbl.push_back('{1, -1, 1, -64'sd1, 10});
    tbl.push_back('{1, 0, -128, 64'sd0, 10});
`ifdef MULT_PIPE_ROUND_EN
    tbl.push_back('{2, 384, 1, 64'sd2, 16});
    tbl.push_back('{2, 384, -1, -64'sd1, 16});
    tbl.push_back('{2, 128, 1, 64'sd1, 16});
`else
    tbl.push_back('{2, 384, 1, 64'sd1, 16});
    tbl.push_back('{2, 384, -1, -64'sd2, 16});
    tbl.push_back('{2, 128, 1, 64'sd0, 16});
`endif
    tbl.push_back('{2, 383, 1, 64'sd1, 16});
    tbl.push_back('{3, 15, 15, 64'sd225, 6});
    tbl.push_back('{3, 8, 9, 64'sd72, 6});
    tbl.push_back('{3, 1, 15, 64'sd15, 6});

    step();
    step();
    for (int s = 0; s < 4; s++) begin
      get(s, ov, p);
      chk($sformatf("reset_ov%0d", s), ov, 0);
      chk($sformatf("reset_prod%0d", s), p, 0);
    end
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // back-to-back traffic with a 1-0-1-1 valid pattern
    sent = 0; pos = 0; guard = 0;
    while ((sent < 20 || q.size() > 0) && guard < 200) begin
      if (sent < 20 && pat[pos % 4]) begin
        ra = 26'($urandom);
        rb = 14'($urandom);
        la = longint'(ra);
        lb = rb[13] ? longint'(rb) - 64'sd16384 : longint'(rb);
        drive(0, {6'd0, ra}, {{18{rb[13]}}, rb}, 1'b1);
        q.push_back('{la * lb, cyc + 17});
        sent++;
      end else begin
        drive(0, 0, 0, 1'b0);
      end
      pos++;
      step();
      guard++;
      get(0, ov, p);
      exp_ov = (q.size() > 0) && (q[0].due == cyc);
      chk($sformatf("b2b_ov_cyc%0d", cyc), ov, exp_ov);
      if (ov && q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("b2b_prod_cyc%0d", cyc), p, e.v);
      end else if (exp_ov) begin
        void'(q.pop_front());
      end
    end
    chk("b2b_drained", q.size(), 0);

    // reset while five operations are in flight
    for (int i = 0; i < 5; i++) begin
      drive(0, 100 + i, 7, 1'b1);
      step();
    end
    drive(0, 0, 0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    get(0, ov, p);
    chk("midrst_ov", ov, 0);
    chk("midrst_prod", p, 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ov0) pulses++;
    end
    chk("midrst_flush_pulses", pulses, 0);
    run_vec(100, '{0, 1000, -3, -64'sd3000, 16});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
